enemy_sprite_plotter: RTL and testbench

Downstream stage of the enemy meta datapath. It consumes the enemy origin (`x_in`, `y_in`) and the `start_plot` request, erases the enemy's previous bounding box, then redraws the sprite at the new origin from an external sprite ROM. It drives the VGA adapter pixel-write port with one pixel per cycle. It is also the enemy's input to the shared plot arbiter, which it notifies through `busy` and `done`.

---
 rtl/enemy_sprite_plotter.sv | 221 ++++++++++++++++++++++
 tb/tb_enemy_sprite_plotter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_sprite_plotter.sv
// Enemy sprite plotter: erases the previous bounding box, then redraws the sprite
// from an external synchronous ROM, emitting one VGA pixel per cycle.
module enemy_sprite_plotter #(
   parameter int unsigned SPRITE_W     = 16,
   parameter int unsigned SPRITE_H     = 16,
   parameter int unsigned ADDR_W       = 8,
   parameter logic [2:0]  ERASE_COLOUR = 3'b000,
   parameter logic [2:0]  TRANSPARENT  = 3'b111
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              start_plot,
   input  logic [7:0]        x_in,
   input  logic [6:0]        y_in,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [2:0]        rom_data,
   output logic [7:0]        x_out,
   output logic [6:0]        y_out,
   output logic [2:0]        colour,
   output logic              writeEn,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int unsigned RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(SPRITE_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(SPRITE_H - 1);

   typedef enum logic [2:0] {S_IDLE, S_ERASE, S_DRAW, S_FLUSH, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     col_q, col_d, col_nx;
   logic [RW-1:0]     row_q, row_d, row_nx;
   logic [7:0]        nx_q, nx_d, ox_q, ox_d;
   logic [6:0]        ny_q, ny_d, oy_q, oy_d;
   logic              has_prev_q, has_prev_d;
   logic [7:0]        x_out_q, x_out_d;
   logic [6:0]        y_out_q, y_out_d;
   logic [2:0]        colour_q, colour_d;
   logic              we_q, we_d;
   logic              draw_q, draw_d;
   logic              vis_q, vis_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              last;
   logic [8:0]        px_x;
   logic [7:0]        px_y;

   function automatic logic [8:0] sum_x(input logic [7:0] b, input logic [CW-1:0] c);
      return {1'b0, b} + 9'(c);
   endfunction

   function automatic logic [7:0] sum_y(input logic [6:0] b, input logic [RW-1:0] r);
      return {1'b0, b} + 8'(r);
   endfunction

   function automatic logic on_screen(input logic [8:0] sx, input logic [7:0] sy);
      return (sx <= 9'd159) && (sy <= 8'd119);
   endfunction

   function automatic logic [ADDR_W-1:0] addr_of(input logic [CW-1:0] c, input logic [RW-1:0] r);
      return ADDR_W'(r) * ADDR_W'(SPRITE_W) + ADDR_W'(c);
   endfunction

   assign last   = (col_q == COL_LAST) && (row_q == ROW_LAST);
   assign col_nx = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
   assign row_nx = (col_q == COL_LAST) ? row_q + 1'b1 : row_q;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start_plot) state_d = has_prev_q ? S_ERASE : S_DRAW;
         S_ERASE: if (last) state_d = S_DRAW;
         S_DRAW:  if (last) state_d = S_FLUSH;
         S_FLUSH: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are loaded one edge ahead, so each branch computes the pixel shown next cycle.
   always_comb begin
      col_d      = col_q;
      row_d      = row_q;
      nx_d       = nx_q;
      ny_d       = ny_q;
      ox_d       = ox_q;
      oy_d       = oy_q;
      has_prev_d = has_prev_q;
      x_out_d    = x_out_q;
      y_out_d    = y_out_q;
      colour_d   = colour_q;
      we_d       = 1'b0;
      draw_d     = 1'b0;
      vis_d      = 1'b0;
      rom_addr_d = rom_addr_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      px_x       = '0;
      px_y       = '0;
      unique case (state_q)
         S_IDLE: begin
            if (start_plot) begin
               nx_d       = x_in;
               ny_d       = y_in;
               col_d      = '0;
               row_d      = '0;
               rom_addr_d = '0;
               busy_d     = 1'b1;
               if (has_prev_q) begin
                  px_x     = sum_x(ox_q, '0);
                  px_y     = sum_y(oy_q, '0);
                  x_out_d  = px_x[7:0];
                  y_out_d  = px_y[6:0];
                  colour_d = ERASE_COLOUR;
                  we_d     = on_screen(px_x, px_y);
               end
            end
         end
         S_ERASE: begin
            if (last) begin
               col_d      = '0;
               row_d      = '0;
               rom_addr_d = '0;
            end else begin
               col_d    = col_nx;
               row_d    = row_nx;
               px_x     = sum_x(ox_q, col_nx);
               px_y     = sum_y(oy_q, row_nx);
               x_out_d  = px_x[7:0];
               y_out_d  = px_y[6:0];
               colour_d = ERASE_COLOUR;
               we_d     = on_screen(px_x, px_y);
            end
         end
         S_DRAW: begin
            px_x    = sum_x(nx_q, col_q);
            px_y    = sum_y(ny_q, row_q);
            x_out_d = px_x[7:0];
            y_out_d = px_y[6:0];
            draw_d  = 1'b1;
            vis_d   = on_screen(px_x, px_y);
            if (last) begin
               col_d      = '0;
               row_d      = '0;
               rom_addr_d = '0;
            end else begin
               col_d      = col_nx;
               row_d      = row_nx;
               rom_addr_d = addr_of(col_nx, row_nx);
            end
         end
         S_FLUSH: done_d = 1'b1;
         S_DONE: begin
            busy_d     = 1'b0;
            ox_d       = nx_q;
            oy_d       = ny_q;
            has_prev_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         col_q      <= '0;
         row_q      <= '0;
         nx_q       <= '0;
         ny_q       <= '0;
         ox_q       <= '0;
         oy_q       <= '0;
         has_prev_q <= 1'b0;
         x_out_q    <= '0;
         y_out_q    <= '0;
         colour_q   <= '0;
         we_q       <= 1'b0;
         draw_q     <= 1'b0;
         vis_q      <= 1'b0;
         rom_addr_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         nx_q       <= nx_d;
         ny_q       <= ny_d;
         ox_q       <= ox_d;
         oy_q       <= oy_d;
         has_prev_q <= has_prev_d;
         x_out_q    <= x_out_d;
         y_out_q    <= y_out_d;
         colour_q   <= colour_d;
         we_q       <= we_d;
         draw_q     <= draw_d;
         vis_q      <= vis_d;
         rom_addr_q <= rom_addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // ROM data arrives in the pixel's own cycle, so draw colour/strobe are gated from registered flags.
   assign writeEn  = draw_q ? (vis_q && (rom_data != TRANSPARENT)) : we_q;
   assign colour   = draw_q ? rom_data : colour_q;
   assign x_out    = x_out_q;
   assign y_out    = y_out_q;
   assign rom_addr = rom_addr_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_enemy_sprite_plotter.sv
// Self-checking bench for enemy_sprite_plotter: per-cycle pixel stream compared with a
// reference built from the erase/draw/clip/transparency rules.
module tb_enemy_sprite_plotter;
   localparam int W = 16;
   localparam int H = 16;
   localparam int N = W * H;
   localparam int MAXC = 600;

   logic       clock = 1'b0;
   logic       resetn, start_plot;
   logic [7:0] x_in;
   logic [6:0] y_in;
   logic [7:0] rom_addr;
   logic [2:0] rom_data;
   logic [7:0] x_out;
   logic [6:0] y_out;
   logic [2:0] colour;
   logic       writeEn, busy, done;

   enemy_sprite_plotter #(
      .SPRITE_W(W), .SPRITE_H(H), .ADDR_W(8), .ERASE_COLOUR(3'b000), .TRANSPARENT(3'b111)
   ) dut (
      .clock(clock), .resetn(resetn), .start_plot(start_plot), .x_in(x_in), .y_in(y_in),
      .rom_addr(rom_addr), .rom_data(rom_data), .x_out(x_out), .y_out(y_out),
      .colour(colour), .writeEn(writeEn), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   logic [2:0] rom_mem [0:N-1];
   always @(posedge clock) rom_data <= rom_mem[rom_addr];

   int checks = 0;
   int passed = 0;

   bit   m_has_prev;
   int   m_ox, m_oy;

   bit         exp_we [1:MAXC];
   logic [7:0] exp_x  [1:MAXC];
   logic [6:0] exp_y  [1:MAXC];
   logic [2:0] exp_c  [1:MAXC];
   int         exp_done;

   logic       obs_we [1:MAXC];
   logic [7:0] obs_x  [1:MAXC];
   logic [6:0] obs_y  [1:MAXC];
   logic [2:0] obs_c  [1:MAXC];
   logic       obs_busy [1:MAXC];
   logic       obs_done [1:MAXC];
   int         done_cyc;

   function automatic void build_expect(input int nx, input int ny);
      int base, k, x, y;
      exp_done = m_has_prev ? 2 * N + 2 : N + 2;
      for (int i = 1; i <= MAXC; i++) begin
         exp_we[i] = 1'b0; exp_x[i] = '0; exp_y[i] = '0; exp_c[i] = '0;
      end
      if (m_has_prev) begin
         for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
               k = 1 + r * W + c; x = m_ox + c; y = m_oy + r;
               if (x < 160 && y < 120) begin
                  exp_we[k] = 1'b1; exp_x[k] = 8'(x); exp_y[k] = 7'(y); exp_c[k] = 3'b000;
               end
            end
         end
      end
      base = m_has_prev ? N + 2 : 2;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            k = base + r * W + c; x = nx + c; y = ny + r;
            if (x < 160 && y < 120 && rom_mem[r * W + c] != 3'b111) begin
               exp_we[k] = 1'b1; exp_x[k] = 8'(x); exp_y[k] = 7'(y); exp_c[k] = rom_mem[r * W + c];
            end
         end
      end
   endfunction

   task automatic run_frame(input int nx, input int ny, input bit hold, input int change_at, input int new_x);
      @(negedge clock);
      x_in = 8'(nx); y_in = 7'(ny); start_plot = 1'b1;
      build_expect(nx, ny);
      for (int i = 1; i <= MAXC; i++) begin
         obs_we[i] = 1'bx; obs_x[i] = 'x; obs_y[i] = 'x; obs_c[i] = 'x; obs_busy[i] = 1'bx; obs_done[i] = 1'bx;
      end
      done_cyc = 0;
      @(posedge clock); #1;
      if (!hold) start_plot = 1'b0;
      for (int k = 1; k <= MAXC; k++) begin
         @(negedge clock);
         if (k == change_at) x_in = 8'(new_x);
         obs_we[k] = writeEn; obs_x[k] = x_out; obs_y[k] = y_out; obs_c[k] = colour;
         obs_busy[k] = busy; obs_done[k] = done;
         if (done === 1'b1) begin
            done_cyc = k;
            break;
         end
      end
      m_ox = nx; m_oy = ny; m_has_prev = 1'b1;
   endtask

   function automatic int frame_errs(output int first_bad);
      int errs = 0;
      bit bad;
      first_bad = 1;
      for (int k = 1; k <= exp_done; k++) begin
         bad = 1'b0;
         if (obs_we[k] !== exp_we[k]) bad = 1'b1;
         else if (exp_we[k] && (obs_x[k] !== exp_x[k] || obs_y[k] !== exp_y[k] || obs_c[k] !== exp_c[k])) bad = 1'b1;
         if (obs_busy[k] !== 1'b1) bad = 1'b1;
         if (obs_done[k] !== (k == exp_done)) bad = 1'b1;
         if (bad) begin
            if (errs == 0) first_bad = k;
            errs++;
         end
      end
      return errs;
   endfunction

   function automatic int count_writes(input int lo, input int hi);
      int n = 0;
      for (int k = lo; k <= hi; k++) if (obs_we[k] === 1'b1) n++;
      return n;
   endfunction

   task automatic test_reset();
      resetn = 1'b0; start_plot = 1'b0; x_in = '0; y_in = '0;
      repeat (3) @(negedge clock);
      checks++;
      if ({x_out, y_out, colour, writeEn, rom_addr, busy, done} !== '0)
         $display("FAIL reset_outputs: x=%0d y=%0d c=%b we=%b addr=%0d busy=%b done=%b, required all 0",
                  x_out, y_out, colour, writeEn, rom_addr, busy, done);
      else passed++;
      resetn = 1'b1;
      m_has_prev = 1'b0; m_ox = 0; m_oy = 0;
      repeat (4) @(negedge clock);
      checks++;
      if ({writeEn, busy, done} !== 3'b000)
         $display("FAIL idle_quiet: we=%b busy=%b done=%b, required 000", writeEn, busy, done);
      else passed++;
   endtask

   task automatic test_first_plot();
      int fb, errs;
      for (int a = 0; a < N; a++) rom_mem[a] = 3'b010;
      run_frame(40, 30, 1'b0, 0, 0);
      errs = frame_errs(fb);
      checks++;
      if (errs !== 0) $display("FAIL first_stream: %0d bad cycles, first t+%0d got we=%b x=%0d y=%0d c=%b, required we=%b x=%0d y=%0d c=%b",
                               errs, fb, obs_we[fb], obs_x[fb], obs_y[fb], obs_c[fb], exp_we[fb], exp_x[fb], exp_y[fb], exp_c[fb]);
      else passed++;
      checks++;
      if (done_cyc !== 258) $display("FAIL first_done: done at t+%0d, required t+258", done_cyc);
      else passed++;
      checks++;
      if (count_writes(1, 257) !== 256) $display("FAIL first_writes: %0d writes, required 256", count_writes(1, 257));
      else passed++;
   endtask

   task automatic test_second_plot();
      int fb, errs;
      run_frame(60, 30, 1'b0, 0, 0);
      errs = frame_errs(fb);
      checks++;
      if (errs !== 0) $display("FAIL second_stream: %0d bad cycles, first t+%0d got we=%b x=%0d y=%0d c=%b, required we=%b x=%0d y=%0d c=%b",
                               errs, fb, obs_we[fb], obs_x[fb], obs_y[fb], obs_c[fb], exp_we[fb], exp_x[fb], exp_y[fb], exp_c[fb]);
      else passed++;
      checks++;
      if (done_cyc !== 514) $display("FAIL second_done: done at t+%0d, required t+514", done_cyc);
      else passed++;
      checks++;
      if (count_writes(1, 256) !== 256 || count_writes(257, 513) !== 256)
         $display("FAIL second_writes: erase %0d draw %0d, required 256 and 256", count_writes(1, 256), count_writes(257, 513));
      else passed++;
   endtask

   task automatic test_transparency();
      int fb, errs;
      for (int a = 0; a < N; a++) rom_mem[a] = (a % 2 == 1) ? 3'b111 : 3'b100;
      run_frame(20, 10, 1'b0, 0, 0);
      errs = frame_errs(fb);
      checks++;
      if (errs !== 0) $display("FAIL transp_stream: %0d bad cycles, first t+%0d got we=%b c=%b, required we=%b c=%b",
                               errs, fb, obs_we[fb], obs_c[fb], exp_we[fb], exp_c[fb]);
      else passed++;
      checks++;
      if (count_writes(258, 513) !== 128) $display("FAIL transp_writes: %0d draw writes, required 128", count_writes(258, 513));
      else passed++;
      checks++;
      if (done_cyc !== 514) $display("FAIL transp_done: done at t+%0d, required t+514", done_cyc);
      else passed++;
   endtask

   task automatic test_clipping();
      int fb, errs;
      for (int a = 0; a < N; a++) rom_mem[a] = 3'b010;
      run_frame(150, 110, 1'b0, 0, 0);
      errs = frame_errs(fb);
      checks++;
      if (errs !== 0) $display("FAIL clip_stream: %0d bad cycles, first t+%0d got we=%b x=%0d y=%0d, required we=%b x=%0d y=%0d",
                               errs, fb, obs_we[fb], obs_x[fb], obs_y[fb], exp_we[fb], exp_x[fb], exp_y[fb]);
      else passed++;
      checks++;
      if (count_writes(258, 513) !== 100) $display("FAIL clip_writes: %0d draw writes, required 100", count_writes(258, 513));
      else passed++;
      checks++;
      if (done_cyc !== 514) $display("FAIL clip_done: done at t+%0d, required t+514", done_cyc);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int fb, errs;
      run_frame(40, 30, 1'b1, 5, 80);
      errs = frame_errs(fb);
      checks++;
      if (errs !== 0) $display("FAIL held_first_stream: %0d bad cycles, first t+%0d got we=%b x=%0d, required we=%b x=%0d",
                               errs, fb, obs_we[fb], obs_x[fb], exp_we[fb], exp_x[fb]);
      else passed++;
      run_frame(80, 30, 1'b0, 0, 0);
      errs = frame_errs(fb);
      checks++;
      if (errs !== 0) $display("FAIL held_second_stream: %0d bad cycles, first t+%0d got we=%b x=%0d, required we=%b x=%0d",
                               errs, fb, obs_we[fb], obs_x[fb], exp_we[fb], exp_x[fb]);
      else passed++;
      checks++;
      if (done_cyc !== 514) $display("FAIL held_second_done: done at t+%0d, required t+514", done_cyc);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int fb, errs, stray;
      @(negedge clock);
      x_in = 8'd10; y_in = 7'd5; start_plot = 1'b1;
      @(posedge clock); #1;
      start_plot = 1'b0;
      repeat (300) @(negedge clock);
      resetn = 1'b0;
      @(negedge clock);
      checks++;
      if ({x_out, y_out, colour, writeEn, rom_addr, busy, done} !== '0)
         $display("FAIL midreset_outputs: x=%0d y=%0d c=%b we=%b addr=%0d busy=%b done=%b, required all 0",
                  x_out, y_out, colour, writeEn, rom_addr, busy, done);
      else passed++;
      stray = 0;
      repeat (3) begin
         @(negedge clock);
         if (writeEn !== 1'b0) stray++;
      end
      checks++;
      if (stray !== 0) $display("FAIL midreset_quiet: %0d writes in reset, required 0", stray);
      else passed++;
      resetn = 1'b1;
      m_has_prev = 1'b0; m_ox = 0; m_oy = 0;
      run_frame(100, 50, 1'b0, 0, 0);
      errs = frame_errs(fb);
      checks++;
      if (errs !== 0) $display("FAIL midreset_stream: %0d bad cycles, first t+%0d got we=%b x=%0d, required we=%b x=%0d",
                               errs, fb, obs_we[fb], obs_x[fb], exp_we[fb], exp_x[fb]);
      else passed++;
      checks++;
      if (done_cyc !== 258) $display("FAIL midreset_done: done at t+%0d, required t+258 (no erase)", done_cyc);
      else passed++;
   endtask

   task automatic test_random();
      int fb, errs, rx, ry;
      for (int f = 0; f < 4; f++) begin
         for (int a = 0; a < N; a++) rom_mem[a] = 3'($urandom_range(7, 0));
         rx = int'($urandom_range(175, 0));
         ry = int'($urandom_range(127, 0));
         run_frame(rx, ry, 1'b0, 0, 0);
         errs = frame_errs(fb);
         checks++;
         if (errs !== 0) $display("FAIL random_stream[%0d] (%0d,%0d): %0d bad cycles, first t+%0d got we=%b x=%0d y=%0d c=%b, required we=%b x=%0d y=%0d c=%b",
                                  f, rx, ry, errs, fb, obs_we[fb], obs_x[fb], obs_y[fb], obs_c[fb], exp_we[fb], exp_x[fb], exp_y[fb], exp_c[fb]);
         else passed++;
         checks++;
         if (done_cyc !== exp_done) $display("FAIL random_done[%0d]: done at t+%0d, required t+%0d", f, done_cyc, exp_done);
         else passed++;
      end
   endtask

   initial begin
      for (int a = 0; a < N; a++) rom_mem[a] = 3'b000;
      test_reset();
      test_first_plot();
      test_second_plot();
      test_transparency();
      test_clipping();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
